// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage multiply / multiply-accumulate pipeline with valid/ready handshake.
// A single output stall freezes every stage; the accumulator is updated only in S3.
module lcv_mul_acc_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 48,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp_valid,
    output logic                 inp_ready,
    input  logic [1:0]           inp_op,
    input  logic                 inp_signed,
    input  logic [IN_WIDTH-1:0]  inp_a,
    input  logic [IN_WIDTH-1:0]  inp_b,
    input  logic [ACC_WIDTH-1:0] inp_c,
    output logic                 outp_valid,
    input  logic                 outp_ready,
    output logic [ACC_WIDTH-1:0] outp_data,
    output logic                 outp_ovf
);

    localparam int PW = 2 * IN_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MAC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    generate
        if (ACC_WIDTH < 2 * IN_WIDTH + 1) begin : g_width_check
            $error("lcv_mul_acc_pipe: ACC_WIDTH must be at least 2*IN_WIDTH+1");
        end
    endgenerate

    logic                 s1_valid_q, s1_valid_d;
    op_e                  s1_op_q, s1_op_d;
    logic                 s1_signed_q, s1_signed_d;
    logic [IN_WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [IN_WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [ACC_WIDTH-1:0] s1_c_q, s1_c_d;

    logic                 s2_valid_q, s2_valid_d;
    op_e                  s2_op_q, s2_op_d;
    logic [ACC_WIDTH-1:0] s2_prod_q, s2_prod_d;
    logic [ACC_WIDTH-1:0] s2_c_q, s2_c_d;

    logic                 outp_valid_q, outp_valid_d;
    logic [ACC_WIDTH-1:0] outp_data_q, outp_data_d;
    logic                 outp_ovf_q, outp_ovf_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;

    logic                 advance;
    logic [PW-1:0]        a_ext, b_ext, prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] add_x, add_y, sum, sum_sat, result;
    logic                 sum_ovf, result_ovf;

    assign inp_ready  = advance;
    assign outp_valid = outp_valid_q;
    assign outp_data  = outp_data_q;
    assign outp_ovf   = outp_ovf_q;

    // Operands are widened to the product width first, so one multiplier serves both signednesses.
    always_comb begin
        advance  = !(outp_valid_q && !outp_ready);
        a_ext    = {{IN_WIDTH{s1_signed_q & s1_a_q[IN_WIDTH-1]}}, s1_a_q};
        b_ext    = {{IN_WIDTH{s1_signed_q & s1_b_q[IN_WIDTH-1]}}, s1_b_q};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_WIDTH-PW){s1_signed_q & prod[PW-1]}}, prod};

        if (s2_op_q == OP_MUL) begin
            add_x = s2_prod_q;
            add_y = s2_c_q;
        end else begin
            add_x = acc_q;
            add_y = s2_prod_q;
        end
        sum     = add_x + add_y;
        sum_ovf = (add_x[ACC_WIDTH-1] == add_y[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != add_x[ACC_WIDTH-1]);
        if ((SATURATE != 0) && sum_ovf) begin
            sum_sat = add_x[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum;
        end

        case (s2_op_q)
            OP_MUL, OP_MAC: begin
                result     = sum_sat;
                result_ovf = sum_ovf;
            end
            OP_LOAD: begin
                result     = s2_c_q;
                result_ovf = 1'b0;
            end
            default: begin
                result     = '0;
                result_ovf = 1'b0;
            end
        endcase
    end

    // All stages move together; a stall simply holds every register.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_signed_d  = s1_signed_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_c_d       = s1_c_q;
        s2_valid_d   = s2_valid_q;
        s2_op_d      = s2_op_q;
        s2_prod_d    = s2_prod_q;
        s2_c_d       = s2_c_q;
        outp_valid_d = outp_valid_q;
        outp_data_d  = outp_data_q;
        outp_ovf_d   = outp_ovf_q;
        acc_d        = acc_q;

        if (advance) begin
            s1_valid_d = inp_valid;
            if (inp_valid) begin
                s1_op_d     = op_e'(inp_op);
                s1_signed_d = inp_signed;
                s1_a_d      = inp_a;
                s1_b_d      = inp_b;
                s1_c_d      = inp_c;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_op_d   = s1_op_q;
                s2_prod_d = prod_ext;
                s2_c_d    = s1_c_q;
            end
            outp_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                outp_data_d = result;
                outp_ovf_d  = result_ovf;
                if (s2_op_q != OP_MUL) begin
                    acc_d = result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_MUL;
            s1_signed_q  <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_c_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_op_q      <= OP_MUL;
            s2_prod_q    <= '0;
            s2_c_q       <= '0;
            outp_valid_q <= 1'b0;
            outp_data_q  <= '0;
            outp_ovf_q   <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_signed_q  <= s1_signed_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_c_q       <= s1_c_d;
            s2_valid_q   <= s2_valid_d;
            s2_op_q      <= s2_op_d;
            s2_prod_q    <= s2_prod_d;
            s2_c_q       <= s2_c_d;
            outp_valid_q <= outp_valid_d;
            outp_data_q  <= outp_data_d;
            outp_ovf_q   <= outp_ovf_d;
            acc_q        <= acc_d;
        end
    end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Directed bench: a wrapping and a saturating instance share every input,
// so both overflow behaviours are observed on the same stimulus.
module tb_lcv_mul_acc_pipe;

    localparam int IW = 16;
    localparam int AW = 40;
    localparam logic [AW-1:0] MAX40 = 40'h7F_FFFF_FFFF;
    localparam logic [AW-1:0] MIN40 = 40'h80_0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          inp_valid;
    logic [1:0]    inp_op;
    logic          inp_signed;
    logic [IW-1:0] inp_a, inp_b;
    logic [AW-1:0] inp_c;
    logic          outp_ready;

    logic          inp_ready0, outp_valid0, outp_ovf0;
    logic [AW-1:0] outp_data0;
    logic          inp_ready1, outp_valid1, outp_ovf1;
    logic [AW-1:0] outp_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready0), .inp_op(inp_op),
        .inp_signed(inp_signed), .inp_a(inp_a), .inp_b(inp_b), .inp_c(inp_c),
        .outp_valid(outp_valid0), .outp_ready(outp_ready),
        .outp_data(outp_data0), .outp_ovf(outp_ovf0)
    );

    lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready1), .inp_op(inp_op),
        .inp_signed(inp_signed), .inp_a(inp_a), .inp_b(inp_b), .inp_c(inp_c),
        .outp_valid(outp_valid1), .outp_ready(outp_ready),
        .outp_data(outp_data1), .outp_ovf(outp_ovf1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic sgn, input logic [IW-1:0] a,
                         input logic [IW-1:0] b, input logic [AW-1:0] c);
        inp_valid  = 1'b1;
        inp_op     = op;
        inp_signed = sgn;
        inp_a      = a;
        inp_b      = b;
        inp_c      = c;
    endtask

    task automatic idle;
        inp_valid = 1'b0;
        inp_op    = 2'd0;
        inp_a     = '0;
        inp_b     = '0;
        inp_c     = '0;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        outp_ready = 1'b1;
        idle();
        inp_signed = 1'b0;
        tick();
        tick();
        checks++;
        if (outp_valid0 !== 1'b0 || outp_valid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b/%b expected 0", outp_valid0, outp_valid1);
        end
        checks++;
        if (outp_data0 !== '0 || outp_ovf0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %0h ovf %b expected 0 ovf 0", outp_data0, outp_ovf0);
        end
        checks++;
        if (inp_ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", inp_ready0);
        end
        rst = 1'b1;
    endtask

    task automatic test_mul_latency;
        drive(2'd0, 1'b1, -16'sd3, 16'd7, 40'd100);
        tick();
        idle();
        tick();
        checks++;
        if (outp_valid0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_early_valid: got %b expected 0", outp_valid0);
        end
        tick();
        checks++;
        if (outp_valid0 !== 1'b1 || $signed(outp_data0) !== 40'sd79 || outp_ovf0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_latency: got valid %b data %0d ovf %b expected valid 1 data 79 ovf 0",
                     outp_valid0, $signed(outp_data0), outp_ovf0);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0]    ops[4];
        logic [IW-1:0] as[4];
        logic [IW-1:0] bs[4];
        logic [AW-1:0] ex[4];
        ops = '{2'd3, 2'd1, 2'd1, 2'd1};
        as  = '{16'd0, 16'd2, 16'd4, 16'hFFFF};
        bs  = '{16'd0, 16'd3, 16'd5, 16'd6};
        ex  = '{40'd0, 40'd6, 40'd26, 40'd20};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(ops[i], 1'b1, as[i], bs[i], 40'd0);
            else idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (outp_valid0 !== 1'b1 || outp_data0 !== ex[i-2] || outp_ovf0 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mac_chain[%0d]: got valid %b data %0d expected valid 1 data %0d",
                             i - 2, outp_valid0, $signed(outp_data0), $signed(ex[i-2]));
                end
            end
        end
        tick();
    endtask

    task automatic test_signedness;
        logic [AW-1:0] ex[2];
        ex = '{40'd131070, 40'hFF_FFFF_FFFE};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) drive(2'd0, i[0], 16'hFFFF, 16'd2, 40'd0);
            else idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (outp_valid0 !== 1'b1 || outp_data0 !== ex[i-2]) begin
                    errors++;
                    $display("[TB] FAIL mul_sign[%0d]: got valid %b data %0d expected %0d",
                             i - 2, outp_valid0, $signed(outp_data0), $signed(ex[i-2]));
                end
            end
        end
        tick();
    endtask

    task automatic test_stall;
        int sent = 0;
        int rx   = 0;
        logic [AW-1:0] ex[8];
        for (int i = 0; i < 8; i++) ex[i] = AW'(13 * i + 3);
        for (int cy = 0; cy < 40 && rx < 8; cy++) begin
            outp_ready = !(cy >= 5 && cy <= 8);
            #1;
            if (!outp_ready) begin
                checks++;
                if (inp_ready0 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_ready cy%0d: got %b expected 0", cy, inp_ready0);
                end
                checks++;
                if (outp_valid0 !== 1'b1 || outp_data0 !== ex[rx]) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cy%0d: got valid %b data %0d expected valid 1 data %0d",
                             cy, outp_valid0, $signed(outp_data0), $signed(ex[rx]));
                end
            end else if (outp_valid0) begin
                checks++;
                if (outp_data0 !== ex[rx]) begin
                    errors++;
                    $display("[TB] FAIL stream[%0d]: got %0d expected %0d",
                             rx, $signed(outp_data0), $signed(ex[rx]));
                end
                rx++;
            end
            if (sent < 8 && inp_ready0) begin
                drive(2'd0, 1'b0, IW'(sent + 1), 16'd3, AW'(10 * sent));
                sent++;
            end else begin
                idle();
            end
            tick();
        end
        outp_ready = 1'b1;
        idle();
        checks++;
        if (rx != 8) begin
            errors++;
            $display("[TB] FAIL stream_count: got %0d results expected 8", rx);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outp_valid0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_extra: got valid %b expected 0", outp_valid0);
            end
        end
    endtask

    task automatic test_saturate;
        logic [1:0]    ops[3];
        logic [IW-1:0] ab[3];
        logic [AW-1:0] ex_wrap[3];
        logic [AW-1:0] ex_sat[3];
        logic          ex_ovf[3];
        ops     = '{2'd2, 2'd1, 2'd1};
        ab      = '{16'd0, 16'd1, 16'd0};
        ex_wrap = '{MAX40, MIN40, MIN40};
        ex_sat  = '{MAX40, MAX40, MAX40};
        ex_ovf  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(ops[i], 1'b1, ab[i], ab[i], MAX40);
            else idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (outp_valid0 !== 1'b1 || outp_data0 !== ex_wrap[i-2] || outp_ovf0 !== ex_ovf[i-2]) begin
                    errors++;
                    $display("[TB] FAIL wrap[%0d]: got data %0h ovf %b expected data %0h ovf %b",
                             i - 2, outp_data0, outp_ovf0, ex_wrap[i-2], ex_ovf[i-2]);
                end
                checks++;
                if (outp_valid1 !== 1'b1 || outp_data1 !== ex_sat[i-2] || outp_ovf1 !== ex_ovf[i-2]) begin
                    errors++;
                    $display("[TB] FAIL sat[%0d]: got data %0h ovf %b expected data %0h ovf %b",
                             i - 2, outp_data1, outp_ovf1, ex_sat[i-2], ex_ovf[i-2]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_flush;
        drive(2'd2, 1'b1, 16'd0, 16'd0, 40'd55);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(2'd1, 1'b1, 16'd1, 16'd1, 40'd0);
            tick();
        end
        idle();
        rst = 1'b0;
        tick();
        checks++;
        if (outp_valid0 !== 1'b0 || outp_data0 !== '0 || outp_ovf0 !== 1'b0 || inp_ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_reset: got valid %b data %0d ovf %b ready %b expected 0 0 0 1",
                     outp_valid0, $signed(outp_data0), outp_ovf0, inp_ready0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outp_valid0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_stale: got valid %b expected 0", outp_valid0);
            end
        end
        drive(2'd1, 1'b1, 16'd2, 16'd3, 40'd0);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (outp_valid0 !== 1'b1 || outp_data0 !== 40'd6) begin
            errors++;
            $display("[TB] FAIL flush_mac: got valid %b data %0d expected valid 1 data 6",
                     outp_valid0, $signed(outp_data0));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_back_to_back();
        test_signedness();
        test_stall();
        test_saturate();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcv_mul_acc_pipe.md
LCV_MUL_ACC_PIPE -- requirements
Module: lcv_mul_acc_pipe

Interface
REQ-001 Parameter IN_WIDTH, default 16: width of multiplier operands a, b.
REQ-002 Parameter ACC_WIDTH, default 48: width of addend, accumulator and result; SHALL satisfy ACC_WIDTH >= 2*IN_WIDTH+1, elaboration error otherwise.
REQ-003 Parameter SATURATE, default 0: 0 = wrap modulo 2^ACC_WIDTH, 1 = signed clamp.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 inp_valid  in  1  operation presented.
REQ-007 inp_ready  out  1  block can accept this cycle.
REQ-008 inp_op  in  2  0=MUL (a*b+c), 1=MAC (acc+a*b), 2=LOAD (acc<=c), 3=CLR (acc<=0).
REQ-009 inp_signed  in  1  1 = a, b signed; 0 = unsigned.
REQ-010 inp_a, inp_b  in  IN_WIDTH each  multiplier operands.
REQ-011 inp_c  in  ACC_WIDTH signed  addend / load value.
REQ-012 outp_valid  out  1  result available.
REQ-013 outp_ready  in  1  consumer takes result.
REQ-014 outp_data  out  ACC_WIDTH signed  result.
REQ-015 outp_ovf  out  1  result overflowed (wrapped or clamped).

Function
REQ-016 Transfer on input when inp_valid && inp_ready; on output when outp_valid && outp_ready.
REQ-017 inp_ready SHALL equal !(outp_valid && !outp_ready), combinational; stall freezes all three stages together, no bubble-collapse.
REQ-018 Pipeline: S1 registers op/signed/a/b/c; S2 registers full 2*IN_WIDTH product, sign- or zero-extended per op's signed flag; S3 computes result and registers outp_data/outp_ovf/outp_valid.
REQ-019 Latency exactly 3 cycles from accept to outp_valid when unstalled; throughput one op per cycle; results in accept order.
REQ-020 MUL: result = ext(a*b) + c; accumulator unchanged.
REQ-021 MAC: result = acc + ext(a*b); acc <= result in same S3 update, so back-to-back MACs chain without hazard.
REQ-022 LOAD: result = c, acc <= c, ovf=0; CLR: result = 0, acc <= 0, ovf=0.
REQ-023 Overflow: signed overflow of the ACC_WIDTH addition sets outp_ovf=1 for that result only (not sticky).
REQ-024 SATURATE=0: result wraps; SATURATE=1: result (and acc for MAC) clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
REQ-025 Unaccepted cycles insert bubbles; bubbles SHALL NOT modify acc.
REQ-026 While stalled, outp_data/outp_ovf SHALL hold stable and acc SHALL NOT update.

Reset
REQ-027 rst low at clock edge: outp_valid=0, outp_data=0, outp_ovf=0, acc=0, all stage valids cleared; in-flight ops discarded.
REQ-028 inp_ready SHALL be 1 during and after reset (outp_valid=0).
REQ-029 First accept permitted on first edge with rst high.

Verification
REQ-030 IN=16, ACC=40: MUL a=-3, b=7, c=100, signed=1 -> outp_valid exactly 3 cycles later, outp_data=79, ovf=0.
REQ-031 CLR then MAC (2,3),(4,5),(-1,6) back-to-back -> outputs 0, 6, 26, 20 on consecutive cycles.
REQ-032 MUL a=16'hFFFF, b=2, c=0: signed=0 -> 131070; signed=1 -> -2.
REQ-033 Stream 8 MULs, outp_ready low 4 cycles mid-stream -> inp_ready low same cycles, outp_data held, all 8 results delivered once, in order.
REQ-034 LOAD c=2^39-1 then MAC 1*1: SATURATE=1 -> 2^39-1, ovf=1; SATURATE=0 -> -2^39, ovf=1; following MAC 0*0 returns the stored acc.
REQ-035 rst low one cycle with 3 ops in flight -> outp_valid=0 next cycle, no stale result emerges; subsequent MAC 2*3 -> 6 (acc cleared).
